// File: rtl/weight_bit_serializer.sv
// Weight-side feeder for the bit-serial MAC.
// Accepts a vector of signed weights, converts each lane to sign-magnitude
// and emits one magnitude bit-column per beat, lowest column first.
// With SKIP_ZERO_COL set, columns that are zero in every lane are skipped;
// an all-zero vector still produces exactly one beat (column 0, last=1).
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high. A source holds valid and its payload stable until that
// edge; ready may depend combinationally on the consumer's ready (w_ready
// follows out_ready while the last beat is presented).
module weight_bit_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int SKIP_ZERO_COL = 1,
    parameter int MW            = DATA_WIDTH - 1,
    parameter int CW            = (MW > 1) ? $clog2(MW) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [VEC_LENGTH-1:0]            sign,
    output logic [VEC_LENGTH-1:0]            w_bit,
    output logic [CW-1:0]                    column_idx,
    output logic                             last,
    output logic                             state
);

    typedef enum logic {IDLE = 1'b0, SERIAL = 1'b1} state_t;

    state_t                             fsm;
    logic                               ready_en;
    logic [VEC_LENGTH-1:0][MW-1:0]      mag_r;
    logic [MW-1:0]                      mask_r;

    logic [VEC_LENGTH-1:0]              sign_in;
    logic [VEC_LENGTH-1:0][MW-1:0]      mag_in;
    logic [MW-1:0]                      col_mask_in;
    logic [MW-1:0]                      acc_mask;
    logic [CW-1:0]                      first_col;
    logic                               first_last;
    logic [CW-1:0]                      next_col;
    logic                               next_last;
    logic                               accept;

    // Saturating absolute value: the most negative code maps to all-ones.
    function automatic logic [MW-1:0] magnitude(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] neg;
        logic [MW-1:0]         m;
        neg = -w;
        if (!w[DATA_WIDTH-1])
            m = w[MW-1:0];
        else if (w[MW-1:0] == '0)
            m = '1;
        else
            m = neg[MW-1:0];
        return m;
    endfunction

    // Priority encoder: lowest set bit of m at or above position lo (0 if none).
    function automatic logic [CW-1:0] lowest_from(input logic [MW-1:0] m, input logic [CW:0] lo);
        logic [CW-1:0] r;
        r = '0;
        for (int c = MW - 1; c >= 0; c--) begin
            if ((c >= int'(lo)) && m[c])
                r = CW'(c);
        end
        return r;
    endfunction

    // True when m has any set bit strictly above column c.
    function automatic logic any_above(input logic [MW-1:0] m, input logic [CW-1:0] c);
        logic r;
        r = 1'b0;
        for (int k = 0; k < MW; k++) begin
            if ((k > int'(c)) && m[k])
                r = 1'b1;
        end
        return r;
    endfunction

    // Gather bit c of every lane's magnitude into one column.
    function automatic logic [VEC_LENGTH-1:0] column_bits(
        input logic [VEC_LENGTH-1:0][MW-1:0] mg, input logic [CW-1:0] c);
        logic [VEC_LENGTH-1:0] b;
        b = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            for (int k = 0; k < MW; k++) begin
                if (k == int'(c))
                    b[j] = mg[j][k];
            end
        end
        return b;
    endfunction

    // Convert the incoming vector and pick its first column.
    always_comb begin
        sign_in     = '0;
        mag_in      = '0;
        col_mask_in = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            sign_in[j]  = w_in[j*DATA_WIDTH + DATA_WIDTH - 1];
            mag_in[j]   = magnitude(w_in[j*DATA_WIDTH +: DATA_WIDTH]);
            col_mask_in = col_mask_in | mag_in[j];
        end
        acc_mask   = (SKIP_ZERO_COL != 0) ? col_mask_in : '1;
        first_col  = lowest_from(acc_mask, '0);
        first_last = !any_above(acc_mask, first_col);
    end

    // Next emitted column of the vector held in registers.
    always_comb begin
        next_col  = lowest_from(mask_r, {1'b0, column_idx} + 1'b1);
        next_last = !any_above(mask_r, next_col);
    end

    assign w_ready = ready_en & ((fsm == IDLE) | (out_valid & last & out_ready));
    assign accept  = w_valid & w_ready;
    assign state   = fsm;

    // Serializer FSM with registered beat outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= IDLE;
            ready_en   <= 1'b0;
            mag_r      <= '0;
            mask_r     <= '0;
            sign       <= '0;
            w_bit      <= '0;
            column_idx <= '0;
            last       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                fsm        <= SERIAL;
                mag_r      <= mag_in;
                mask_r     <= acc_mask;
                sign       <= sign_in;
                w_bit      <= column_bits(mag_in, first_col);
                column_idx <= first_col;
                last       <= first_last;
                out_valid  <= 1'b1;
            end else if (fsm == SERIAL && out_ready) begin
                if (last) begin
                    fsm        <= IDLE;
                    sign       <= '0;
                    w_bit      <= '0;
                    column_idx <= '0;
                    last       <= 1'b0;
                    out_valid  <= 1'b0;
                end else begin
                    w_bit      <= column_bits(mag_r, next_col);
                    column_idx <= next_col;
                    last       <= next_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed bench for weight_bit_serializer: skip-mode instance plus a
// no-skip instance, hand-computed beats checked with immediate assertions.
module tb_weight_bit_serializer;

    logic        clk = 1'b0;
    logic        reset;

    logic        w_valid, w_ready, out_valid, out_ready, last, state;
    logic [63:0] w_in;
    logic [7:0]  sign, w_bit;
    logic [2:0]  column_idx;

    logic        w_valid_ns, w_ready_ns, out_valid_ns, out_ready_ns, last_ns, state_ns;
    logic [63:0] w_in_ns;
    logic [7:0]  sign_ns, w_bit_ns;
    logic [2:0]  column_idx_ns;

    int n_checks = 0;
    int n_fail   = 0;

    weight_bit_serializer #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(1)) dut (
        .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .w_bit(w_bit),
        .column_idx(column_idx), .last(last), .state(state)
    );

    weight_bit_serializer #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(0)) dut_ns (
        .clk(clk), .reset(reset), .w_valid(w_valid_ns), .w_ready(w_ready_ns), .w_in(w_in_ns),
        .out_valid(out_valid_ns), .out_ready(out_ready_ns), .sign(sign_ns), .w_bit(w_bit_ns),
        .column_idx(column_idx_ns), .last(last_ns), .state(state_ns)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int j, input logic [7:0] v);
        w_in[j*8 +: 8] = v;
    endtask

    task automatic check_beat(input string tag, input logic [2:0] col, input logic [7:0] bits,
                              input logic [7:0] sg, input logic lst);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, ".column_idx"}, 64'(column_idx), 64'(col));
        check({tag, ".w_bit"}, 64'(w_bit), 64'(bits));
        check({tag, ".sign"}, 64'(sign), 64'(sg));
        check({tag, ".last"}, 64'(last), 64'(lst));
    endtask

    initial begin
        reset        = 1'b1;
        w_valid      = 1'b0;
        out_ready    = 1'b0;
        w_in         = '0;
        w_valid_ns   = 1'b0;
        out_ready_ns = 1'b0;
        w_in_ns      = '0;

        // Values while reset is held
        #3;
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.last", 64'(last), 64'(0));
        check("rst.w_ready", 64'(w_ready), 64'(0));
        check("rst.sign", 64'(sign), 64'(0));
        check("rst.w_bit", 64'(w_bit), 64'(0));
        check("rst.column_idx", 64'(column_idx), 64'(0));
        check("rst.state", 64'(state), 64'(0));
        tick();
        check("rst.w_ready_clk", 64'(w_ready), 64'(0));
        reset = 1'b0;
        #1;
        check("rel.w_ready_same", 64'(w_ready), 64'(0));
        tick();
        check("rel.w_ready_next", 64'(w_ready), 64'(1));
        check("rel.w_ready_ns", 64'(w_ready_ns), 64'(1));

        // Sparse columns: lane0 = 5 -> columns 0 and 2
        w_in = '0;
        set_lane(0, 8'd5);
        w_valid   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("sp.w_ready_idle", 64'(w_ready), 64'(1));
        tick();
        w_valid = 1'b0;
        w_in    = '1;
        #1;
        check_beat("sp.b0", 3'd0, 8'h01, 8'h00, 1'b0);
        check("sp.state", 64'(state), 64'(1));
        check("sp.w_ready_b0", 64'(w_ready), 64'(0));
        tick();
        check_beat("sp.b1", 3'd2, 8'h01, 8'h00, 1'b1);
        check("sp.w_ready_last", 64'(w_ready), 64'(1));
        tick();
        check("sp.idle_valid", 64'(out_valid), 64'(0));
        check("sp.idle_state", 64'(state), 64'(0));

        // Negative and saturated weights: lane0 = -3, lane1 = -128
        w_in = '0;
        set_lane(0, 8'hFD);
        set_lane(1, 8'h80);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        #1;
        for (int c = 0; c < 7; c++) begin
            check_beat($sformatf("neg.c%0d", c), 3'(c), (c < 2) ? 8'h03 : 8'h02, 8'h03, c == 6);
            tick();
        end
        check("neg.idle_valid", 64'(out_valid), 64'(0));

        // All-zero vector: one beat at column 0
        w_in    = '0;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        #1;
        check_beat("zero.b0", 3'd0, 8'h00, 8'h00, 1'b1);
        tick();
        check("zero.idle_valid", 64'(out_valid), 64'(0));

        // No-skip instance: lane0 = 64 -> seven beats, bit only at column 6
        w_in_ns       = '0;
        w_in_ns[7:0]  = 8'd64;
        w_valid_ns    = 1'b1;
        out_ready_ns  = 1'b1;
        tick();
        w_valid_ns = 1'b0;
        #1;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("ns.c%0d.valid", c), 64'(out_valid_ns), 64'(1));
            check($sformatf("ns.c%0d.col", c), 64'(column_idx_ns), 64'(c));
            check($sformatf("ns.c%0d.bit", c), 64'(w_bit_ns), (c == 6) ? 64'h01 : 64'h00);
            check($sformatf("ns.c%0d.last", c), 64'(last_ns), (c == 6) ? 64'd1 : 64'd0);
            tick();
        end
        check("ns.idle_valid", 64'(out_valid_ns), 64'(0));

        // Backpressure and back-to-back: A = lane0 5, B = lane3 -8
        w_in = '0;
        set_lane(0, 8'd5);
        w_valid   = 1'b1;
        out_ready = 1'b1;
        tick();
        w_in = '0;
        set_lane(3, 8'hF8);
        #1;
        check_beat("bp.a0", 3'd0, 8'h01, 8'h00, 1'b0);
        check("bp.a0_w_ready", 64'(w_ready), 64'(0));
        tick();
        out_ready = 1'b0;
        #1;
        check_beat("bp.a1", 3'd2, 8'h01, 8'h00, 1'b1);
        check("bp.a1_w_ready", 64'(w_ready), 64'(0));
        tick();
        #1;
        check_beat("bp.a1_stall", 3'd2, 8'h01, 8'h00, 1'b1);
        check("bp.stall_state", 64'(state), 64'(1));
        tick();
        out_ready = 1'b1;
        #1;
        check_beat("bp.a1_drain", 3'd2, 8'h01, 8'h00, 1'b1);
        check("bp.drain_w_ready", 64'(w_ready), 64'(1));
        tick();
        w_valid = 1'b0;
        #1;
        check_beat("bp.b0", 3'd3, 8'h08, 8'h08, 1'b1);
        tick();
        check("bp.idle_valid", 64'(out_valid), 64'(0));

        // Reset during beat 3 of a seven-beat vector (lane1 = -128)
        w_in = '0;
        set_lane(1, 8'h80);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        #1;
        check_beat("mr.b0", 3'd0, 8'h02, 8'h02, 1'b0);
        tick();
        tick();
        check_beat("mr.b2", 3'd2, 8'h02, 8'h02, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("mr.out_valid", 64'(out_valid), 64'(0));
        check("mr.last", 64'(last), 64'(0));
        check("mr.w_ready", 64'(w_ready), 64'(0));
        check("mr.sign", 64'(sign), 64'(0));
        check("mr.state", 64'(state), 64'(0));
        tick();
        reset = 1'b0;
        #1;
        check("mr.w_ready_same", 64'(w_ready), 64'(0));
        tick();
        check("mr.w_ready_next", 64'(w_ready), 64'(1));
        w_in = '0;
        set_lane(0, 8'd5);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        #1;
        check_beat("mr.new0", 3'd0, 8'h01, 8'h00, 1'b0);
        tick();
        check_beat("mr.new1", 3'd2, 8'h01, 8'h00, 1'b1);
        tick();
        check("mr.idle_valid", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_bit_serializer.md
Name: weight_bit_serializer

Overview:
- Weight-side feeder for the bit-serial Wave MAC unit.
- Accepts one vector of VEC_LENGTH signed weights per handshake and converts each weight to sign-magnitude form.
- Emits one magnitude bit-column per beat, as per-lane sign, per-lane w_bit and column_idx, which is exactly the input stream the MAC consumes alongside activations.
- Optionally skips bit-columns that are zero in every lane, so the MAC array spends cycles only on non-zero columns.

Parameters:
- DATA_WIDTH, 8: weight width, two's complement. Magnitude width is DATA_WIDTH-1 = 7 bits, so column_idx runs 0..6.
- VEC_LENGTH, 8: lanes per vector.
- SKIP_ZERO_COL, 1: 1 = drop all-zero columns; 0 = always emit every column 0..DATA_WIDTH-2.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- w_valid, input, 1: weight vector valid.
- w_ready, output, 1: serializer can accept a vector.
- w_in, input, DATA_WIDTH x VEC_LENGTH (signed): weight vector.
- out_valid, output, 1: beat valid.
- out_ready, input, 1: downstream MAC consumes the beat.
- sign, output, 1 x VEC_LENGTH: per-lane weight sign (1 = negative).
- w_bit, output, 1 x VEC_LENGTH: per-lane magnitude bit at column_idx.
- column_idx, output, 3: bit position, used as the MAC shift amount.
- last, output, 1: final beat of the current vector.

Behaviour:
- Reset:
  - Asynchronous clear, which also aborts any vector in progress without draining it.
  - Values while reset is asserted: state=IDLE, out_valid=0, last=0, w_ready=0, all sign=0, all w_bit=0, column_idx=0.
  - w_ready rises the first cycle after reset deasserts.
- Conversion, done at accept into registers:
  - sign[j] = w_in[j] msb.
  - mag[j] = |w_in[j]|, saturated: -128 becomes 127 (mag 7'h7F, sign 1).
  - A zero weight gives sign=0, mag=0.
  - col_mask[c] = OR over all lanes of mag[j][c].
- FSM IDLE:
  - w_ready=1 and out_valid=0.
  - A handshake (w_valid & w_ready) latches sign, mag and col_mask, moves to SERIAL, and asserts out_valid the next cycle with the first column loaded.
- FSM SERIAL:
  - out_valid=1. sign, w_bit, column_idx and last are registered and held stable until out_ready.
  - Columns are emitted in ascending order.
  - SKIP_ZERO_COL=1: only columns with col_mask=1 are emitted. The next column is the lowest set bit of col_mask above the current column, found by a priority encoder.
  - SKIP_ZERO_COL=0: all columns 0..6 are emitted.
  - w_bit[j] = mag[j][column_idx]. sign is constant for the whole vector.
  - last=1 on the highest emitted column.
  - out_ready on a non-last beat advances to the next column in the following cycle.
- All-zero vector (col_mask=0, skip mode): exactly one beat with column_idx=0, all w_bit=0, last=1. This keeps the per-vector beat count at 1 or more, so downstream accumulate/flush logic stays aligned.
- Back-to-back operation:
  - w_ready = IDLE | (out_valid & last & out_ready).
  - A new vector accepted in the same cycle that the last beat drains loads directly into SERIAL with no bubble.
  - Otherwise the FSM returns to IDLE.
- Throughput:
  - One beat per cycle under continuous out_ready.
  - Latency from accept to first out_valid is 1 cycle.
- Stall rule: while out_valid & !out_ready, all outputs hold and the state does not advance.
- w_in is sampled only on a handshake, so changes to w_in at other times have no effect.

Test Plan:
- Reset mid-vector:
  - Stimulus: reset asserted during beat 3 of a 7-beat vector.
  - Required: out_valid and last drop immediately (asynchronously); w_ready=1 one cycle after release; the next vector starts at its first column.
- Skip mode, sparse columns:
  - Stimulus: w_in = {5, 0, 0, 0, 0, 0, 0, 0} (lane0 = 5), out_ready=1.
  - Required: 2 beats, column_idx=0 then 2, w_bit[0]=1 on both beats and all other lanes 0, last on column 2. w_ready is high again in the last-beat cycle.
- Negative and saturated weights:
  - Stimulus: lane0=-3, lane1=-128, others 0.
  - Required: sign={1,1,0,...}. Columns 0..6 are all emitted (lane1 mag=127). Lane0 w_bit=1 only at columns 0 and 1; lane1 w_bit=1 at all 7 columns.
- All-zero vector:
  - Stimulus: all lanes 0.
  - Required: exactly one beat, column_idx=0, w_bit all 0, sign all 0, last=1.
- SKIP_ZERO_COL=0:
  - Stimulus: w_in lane0=64.
  - Required: 7 beats with column_idx 0..6; w_bit[0]=1 only at column 6; last at column 6.
- Backpressure and back-to-back:
  - Stimulus: out_ready toggled 1,0,0,1,...; a second vector held valid the whole time.
  - Required: beats hold stable during stalls and none are lost or duplicated. The second vector is accepted in the cycle its predecessor's last beat handshakes, and its first beat appears the next cycle.
